smi_master: RTL and testbench



---
 rtl/smi_pkg.sv | 23 ++
 rtl/smi_master.sv | 155 +++++++++++++++
 tb/tb_smi_master.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/smi_pkg.sv
// Shared SMI definitions: bus widths, FSM state encoding and slave status-word layout.
package smi_pkg;

    localparam int unsigned SMI_DATA_W = 18;
    localparam int unsigned SMI_ADDR_W = 6;

    // Address of the slave's serial FIFO; reads here return a status word.
    localparam logic [SMI_ADDR_W-1:0] SMI_ADDR_FIFO = 6'h0;

    // Status bits reported by the slave on a FIFO-address read.
    localparam int unsigned SMI_STAT_EMPTY = 8;
    localparam int unsigned SMI_STAT_FULL  = 9;
    localparam int unsigned SMI_STAT_ERR   = 10;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StResp
    } smi_state_e;

endpackage

// File: rtl/smi_master.sv
// SMI initiator: turns read/write commands into timed SMI bus cycles and returns read data.
// Optional build macro SMI_MASTER_SKIP_EMPTY_EN: reads of the FIFO address whose status
// reports the slave TX FIFO empty are consumed without producing a response.
module smi_master
    import smi_pkg::*;
#(
    parameter int unsigned SETUP  = 2,
    parameter int unsigned STROBE = 6,
    parameter int unsigned HOLD   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  S_CMD_VALID,
    output logic                  S_CMD_READY,
    input  logic                  S_CMD_WR,
    input  logic [SMI_ADDR_W-1:0] S_CMD_ADDR,
    input  logic [SMI_DATA_W-1:0] S_CMD_DATA,
    output logic                  M_RSP_VALID,
    input  logic                  M_RSP_READY,
    output logic [SMI_DATA_W-1:0] M_RSP_DATA,
    output logic                  o_smi_oen,
    output logic                  o_smi_wen,
    output logic [SMI_ADDR_W-1:0] o_smi_sa,
    output logic [SMI_DATA_W-1:0] o_smi_data,
    output logic                  o_smi_data_oe,
    input  logic [SMI_DATA_W-1:0] i_smi_data
);

    if (SETUP < 1 || SETUP > 255) begin : gen_bad_setup
        $error("SETUP must be in 1..255");
    end
    if (STROBE < 1 || STROBE > 255) begin : gen_bad_strobe
        $error("STROBE must be in 1..255");
    end
    if (HOLD < 1 || HOLD > 255) begin : gen_bad_hold
        $error("HOLD must be in 1..255");
    end

    smi_state_e            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  live_q;
    logic                  wr_q, wr_d;
    logic [SMI_ADDR_W-1:0] sa_q, sa_d;
    logic [SMI_DATA_W-1:0] wdata_q, wdata_d;
    logic                  oe_q, oe_d;
    logic                  oen_q, oen_d;
    logic                  wen_q, wen_d;
    logic [SMI_DATA_W-1:0] din_q;
    logic [SMI_DATA_W-1:0] rsp_q, rsp_d;
    logic                  skip;

`ifdef SMI_MASTER_SKIP_EMPTY_EN
    assign skip = !wr_q && (sa_q == SMI_ADDR_FIFO) && rsp_q[SMI_STAT_EMPTY];
`else
    assign skip = 1'b0;
`endif

    // Hold READY low until the first edge after reset release.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) live_q <= 1'b0;
        else            live_q <= 1'b1;
    end

    // Bus-cycle sequencer: next state, shared down-counter, latched command and capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        sa_d    = sa_q;
        wdata_d = wdata_q;
        oe_d    = oe_q;
        rsp_d   = rsp_q;
        unique case (state_q)
            StIdle: begin
                if (live_q && S_CMD_VALID) begin
                    state_d = StSetup;
                    cnt_d   = 8'(SETUP - 1);
                    wr_d    = S_CMD_WR;
                    sa_d    = S_CMD_ADDR;
                    wdata_d = S_CMD_DATA;
                    oe_d    = S_CMD_WR;
                end
            end
            StSetup: begin
                if (cnt_q == 8'd0) begin
                    state_d = StStrobe;
                    cnt_d   = 8'(STROBE - 1);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StStrobe: begin
                if (cnt_q == 8'd0) begin
                    state_d = StHold;
                    cnt_d   = 8'(HOLD - 1);
                    if (!wr_q) rsp_d = din_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StHold: begin
                if (cnt_q == 8'd0) begin
                    oe_d    = 1'b0;
                    state_d = (wr_q || skip) ? StIdle : StResp;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StResp: begin
                if (M_RSP_READY) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Strobes are registered from the next state so the pins never glitch.
        oen_d = !((state_d == StStrobe) && !wr_d);
        wen_d = !((state_d == StStrobe) && wr_d);
    end

    // State and pin registers; reset forces strobes high and releases the data pins.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            wr_q    <= 1'b0;
            sa_q    <= '0;
            wdata_q <= '0;
            oe_q    <= 1'b0;
            oen_q   <= 1'b1;
            wen_q   <= 1'b1;
            din_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            sa_q    <= sa_d;
            wdata_q <= wdata_d;
            oe_q    <= oe_d;
            oen_q   <= oen_d;
            wen_q   <= wen_d;
            din_q   <= i_smi_data;
            rsp_q   <= rsp_d;
        end
    end

    assign S_CMD_READY   = live_q && (state_q == StIdle);
    assign M_RSP_VALID   = (state_q == StResp);
    assign M_RSP_DATA    = rsp_q;
    assign o_smi_oen     = oen_q;
    assign o_smi_wen     = wen_q;
    assign o_smi_sa      = sa_q;
    assign o_smi_data    = wdata_q;
    assign o_smi_data_oe = oe_q;

endmodule

// File: tb/tb_smi_master.sv
// Self-checking bench for smi_master: transaction-level timing model plus directed checks.
module tb_smi_master;

    localparam int SETUP  = 2;
    localparam int STROBE = 6;
    localparam int HOLD   = 2;
    localparam int T      = SETUP + STROBE + HOLD;
`ifdef SMI_MASTER_SKIP_EMPTY_EN
    localparam bit SkipEn = 1'b1;
`else
    localparam bit SkipEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_wr = 1'b0;
    logic [5:0]  cmd_addr = '0;
    logic [17:0] cmd_data = '0;
    logic        rsp_ready = 1'b1;
    logic [17:0] smi_din = '0;
    logic        S_CMD_READY, M_RSP_VALID, o_smi_oen, o_smi_wen, o_smi_data_oe;
    logic [17:0] M_RSP_DATA, o_smi_data;
    logic [5:0]  o_smi_sa;

    logic [17:0] mem [64];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Transaction-level model state.
    bit          m_live = 0, m_busy = 0, m_resp = 0, m_wr = 0;
    int          m_t0 = 0;
    logic [5:0]  m_sa = '0;
    logic [17:0] m_data = '0, m_rsp = '0, m_cap = '0;

    smi_master #(.SETUP(SETUP), .STROBE(STROBE), .HOLD(HOLD)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .S_CMD_VALID   (cmd_valid),
        .S_CMD_READY   (S_CMD_READY),
        .S_CMD_WR      (cmd_wr),
        .S_CMD_ADDR    (cmd_addr),
        .S_CMD_DATA    (cmd_data),
        .M_RSP_VALID   (M_RSP_VALID),
        .M_RSP_READY   (rsp_ready),
        .M_RSP_DATA    (M_RSP_DATA),
        .o_smi_oen     (o_smi_oen),
        .o_smi_wen     (o_smi_wen),
        .o_smi_sa      (o_smi_sa),
        .o_smi_data    (o_smi_data),
        .o_smi_data_oe (o_smi_data_oe),
        .i_smi_data    (smi_din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic bit skip_rsp(input logic [5:0] a, input logic [17:0] c);
        return SkipEn && (a == 6'd0) && c[8];
    endfunction

    // Slave: returns its memory word while OEN is low, noise otherwise.
    always @(negedge clk) begin
        #2;
        smi_din = (o_smi_oen === 1'b0) ? mem[o_smi_sa] : 18'($urandom);
    end

    // Model: one command occupies the bus for T cycles from its accept edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_live = 0; m_busy = 0; m_resp = 0; m_wr = 0;
            m_sa = '0; m_data = '0; m_rsp = '0;
        end else begin
            cyc++;
            if (!m_live) begin
                m_live = 1;
            end else if (m_busy) begin
                if (cyc - m_t0 == T) begin
                    m_busy = 0;
                    if (!m_wr && !skip_rsp(m_sa, m_cap)) begin
                        m_resp = 1;
                        m_rsp  = m_cap;
                    end
                end
            end else if (m_resp) begin
                if (rsp_ready) m_resp = 0;
            end else if (cmd_valid) begin
                m_busy = 1; m_t0 = cyc; m_wr = cmd_wr;
                m_sa = cmd_addr; m_data = cmd_data; m_cap = mem[cmd_addr];
            end
        end
    end

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin : cmp
        int k;
        bit stb;
        k   = cyc - m_t0;
        stb = m_busy && k >= SETUP && k < SETUP + STROBE;
        chk("cmd_ready", S_CMD_READY, m_live && !m_busy && !m_resp);
        chk("rsp_valid", M_RSP_VALID, m_resp);
        if (m_resp) chk("rsp_data", M_RSP_DATA, m_rsp);
        chk("oen", o_smi_oen, !(stb && !m_wr));
        chk("wen", o_smi_wen, !(stb && m_wr));
        chk("data_oe", o_smi_data_oe, m_busy && m_wr);
        chk("sa", o_smi_sa, m_sa);
        chk("wdata", o_smi_data, m_data);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [5:0] a, input logic [17:0] d,
                         output int waits);
        logic r;
        waits = 0;
        cmd_wr = wr; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        forever begin
            r = S_CMD_READY;
            @(posedge clk);
            if (r) break;
            waits++;
            if (waits > 200) begin
                total++; bad++;
                $display("FAIL issue_timeout: got no accept want accept within 200 cycles");
                break;
            end
            step();
        end
        step();
        cmd_valid = 1'b0;
    endtask

    // Observe 14 cycles starting at k=0 of a just-accepted command.
    task automatic watch(output int first_low, output int nlow, output int first_rdy,
                         output int first_vld, output int oe_cnt, output logic [17:0] vdata,
                         output logic [17:0] wdat);
        first_low = -1; nlow = 0; first_rdy = -1; first_vld = -1; oe_cnt = 0;
        vdata = '0; wdat = '0;
        for (int k = 0; k < 14; k++) begin
            if (!o_smi_oen || !o_smi_wen) begin
                if (first_low < 0) first_low = k;
                nlow++;
            end
            if (S_CMD_READY && first_rdy < 0) first_rdy = k;
            if (M_RSP_VALID && first_vld < 0) begin
                first_vld = k;
                vdata = M_RSP_DATA;
            end
            if (o_smi_data_oe) oe_cnt++;
            if (k == 5) wdat = o_smi_data;
            step();
        end
    endtask

    initial begin
        int w, fl, nl, fr, fv, oc, nf, prev_wen;
        int fall [8];
        logic [17:0] vd, wd;
        for (int i = 0; i < 64; i++) mem[i] = 18'($urandom);

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", S_CMD_READY, 0);
        chk("rst_rsp_valid", M_RSP_VALID, 0);
        chk("rst_rsp_data", M_RSP_DATA, 0);
        chk("rst_oen", o_smi_oen, 1);
        chk("rst_wen", o_smi_wen, 1);
        chk("rst_sa", o_smi_sa, 0);
        chk("rst_wdata", o_smi_data, 0);
        chk("rst_oe", o_smi_data_oe, 0);
        #1 rst_n = 1'b1;
        chk("ready_before_edge", S_CMD_READY, 0);
        step();
        chk("ready_after_release", S_CMD_READY, 1);

        // Directed write.
        issue(1'b1, 6'd0, 18'h041, w);
        watch(fl, nl, fr, fv, oc, vd, wd);
        chk("wr_strobe_start", fl, 2);
        chk("wr_strobe_len", nl, 6);
        chk("wr_ready_back", fr, 10);
        chk("wr_oe_cycles", oc, 10);
        chk("wr_data_pins", wd, 18'h041);
        chk("wr_no_rsp", fv, -1);

        // Directed read.
        mem[5] = 18'h0055;
        issue(1'b0, 6'd5, 18'h0, w);
        watch(fl, nl, fr, fv, oc, vd, wd);
        chk("rd_strobe_len", nl, 6);
        chk("rd_valid_at", fv, 10);
        chk("rd_data", vd, 18'h0055);
        chk("rd_oe_never", oc, 0);
        chk("rd_ready_back", fr, 11);

        // Backpressure on the response.
        rsp_ready = 1'b0;
        mem[9] = 18'h2a5a5;
        issue(1'b0, 6'd9, 18'h0, w);
        repeat (10) step();
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", M_RSP_VALID, 1);
            chk("bp_data", M_RSP_DATA, 18'h2a5a5);
            chk("bp_cmd_ready", S_CMD_READY, 0);
            step();
        end
        rsp_ready = 1'b1;
        issue(1'b1, 6'd3, 18'h3ffff, w);
        chk("bp_next_start", w, 1);
        repeat (12) step();

        // Back-to-back writes with VALID held high.
        nf = 0; prev_wen = 1;
        cmd_valid = 1'b1; cmd_wr = 1'b1;
        for (int i = 0; i < 44; i++) begin
            if (prev_wen == 1 && o_smi_wen == 1'b0 && nf < 8) begin
                fall[nf] = i;
                nf++;
            end
            prev_wen = int'(o_smi_wen);
            cmd_addr = 6'($urandom);
            cmd_data = 18'($urandom);
            step();
        end
        cmd_valid = 1'b0;
        chk("b2b_strobes", nf >= 4, 1);
        for (int i = 1; i < 4; i++) chk("b2b_period", fall[i] - fall[i-1], 11);
        repeat (15) step();

        // Reset during the strobe: write then read.
        for (int j = 0; j < 2; j++) begin
            mem[7] = 18'h01234;
            issue(j == 0, 6'd7, 18'h15a5a, w);
            repeat (4) step();
            chk("pre_rst_strobe", (j == 0) ? o_smi_wen : o_smi_oen, 0);
            #2 rst_n = 1'b0;
            #1;
            chk("async_rst_oen", o_smi_oen, 1);
            chk("async_rst_wen", o_smi_wen, 1);
            chk("async_rst_oe", o_smi_data_oe, 0);
            repeat (2) step();
            rst_n = 1'b1;
            chk("rel_ready_low", S_CMD_READY, 0);
            step();
            chk("rel_ready_high", S_CMD_READY, 1);
            repeat (12) begin
                chk("rst_no_rsp", M_RSP_VALID, 0);
                step();
            end
        end

        // FIFO-address reads with status empty set and clear.
        mem[0] = 18'h00100;
        issue(1'b0, 6'd0, 18'h0, w);
        watch(fl, nl, fr, fv, oc, vd, wd);
        if (SkipEn) begin
            chk("skip_no_rsp", fv, -1);
            chk("skip_ready_back", fr, 10);
        end else begin
            chk("empty_rsp_at", fv, 10);
            chk("empty_rsp_data", vd, 18'h00100);
        end
        mem[0] = 18'h00041;
        issue(1'b0, 6'd0, 18'h0, w);
        watch(fl, nl, fr, fv, oc, vd, wd);
        chk("fifo_rsp_at", fv, 10);
        chk("fifo_rsp_data", vd, 18'h00041);

        // Randomized traffic, FIFO status empty then non-empty.
        for (int ph = 0; ph < 2; ph++) begin
            mem[0] = 18'($urandom) & ~18'h00100;
            if (ph == 0) mem[0] = mem[0] | 18'h00100;
            for (int i = 0; i < 400; i++) begin
                cmd_valid = ($urandom % 3) != 0;
                cmd_wr    = 1'($urandom);
                cmd_addr  = (($urandom % 4) == 0) ? 6'd0 : 6'($urandom);
                cmd_data  = 18'($urandom);
                rsp_ready = ($urandom % 4) != 0;
                step();
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
            repeat (20) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
